// File: rtl/note_sequencer_pkg.sv
// Shared definitions for the note sequencer: default code width, rest code,
// FSM state encoding and the note-length helper.
package note_sequencer_pkg;

   localparam int DEFAULT_FREQ_W = 12;
   localparam int REST_CODE      = 0;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_NOTE = 2'd1,
      ST_GAP  = 2'd2
   } state_e;

   // A programmed note length of 0 still plays for one tick.
   function automatic logic [8:0] note_target(input logic [7:0] step_ticks);
      return (step_ticks == 8'd0) ? 9'd1 : {1'b0, step_ticks};
   endfunction

endpackage

// File: rtl/note_sequencer_tick_divider.sv
// Tempo prescaler: tick is high in the cycle the count reaches TICK_DIV-1;
// clr restarts the count so a new phase starts on a clean tick boundary.
module tick_divider #(
   parameter int TICK_DIV = 100000
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   output logic tick
);

   localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign tick = (cnt_q == CNT_W'(TICK_DIV - 1));

   always_comb begin
      if (clr || tick) cnt_d = '0;
      else             cnt_d = cnt_q + 1'b1;
   end

   // NOTE: state registers use non-blocking assignments only, so every flop
   // samples the pre-edge values regardless of block ordering.
   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

endmodule

// File: rtl/note_sequencer.sv
// Programmable step sequencer: plays a stored pattern of note codes at a
// programmable tempo with optional per-note silent gap and looping.
module note_sequencer
   import note_sequencer_pkg::*;
#(
   parameter int STEPS    = 16,
   parameter int ADDR_W   = 4,
   parameter int FREQ_W   = DEFAULT_FREQ_W,
   parameter int TICK_DIV = 100000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              stop,
   input  logic              loop_en,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [FREQ_W-1:0] wr_freq,
   input  logic              wr_last,
   input  logic [7:0]        step_ticks,
   input  logic [7:0]        gap_ticks,
   output logic [FREQ_W-1:0] freq,
   output logic              play,
   output logic [ADDR_W-1:0] step_idx,
   output logic              busy,
   output logic              done
);

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   step_idx_q, step_idx_d;
   logic [FREQ_W-1:0]   freq_q, freq_d;
   logic                play_q, play_d;
   logic                done_q, done_d;
   logic [8:0]          ticks_q, ticks_d;

   logic [FREQ_W-1:0]   mem_freq_q [STEPS];
   logic                mem_last_q [STEPS];

   logic                tick;
   logic                clr;
   logic [8:0]          phase_target;
   logic                phase_done;
   logic                is_last;
   logic                load;
   logic [ADDR_W-1:0]   load_idx;

   tick_divider #(
      .TICK_DIV (TICK_DIV)
   ) u_tick_divider (
      .clk  (clk),
      .rst  (rst),
      .clr  (clr),
      .tick (tick)
   );

   // NOTE: the pattern store is reset element by element because a reset
   // must leave every entry reading as a non-final rest.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < STEPS; i++) begin
            mem_freq_q[i] <= '0;
            mem_last_q[i] <= 1'b0;
         end
      end else if (wr_en) begin
         mem_freq_q[wr_addr] <= wr_freq;
         mem_last_q[wr_addr] <= wr_last;
      end
   end

   // Phase lengths are evaluated live so tempo changes apply mid-pattern.
   assign phase_target = (state_q == ST_GAP) ? {1'b0, gap_ticks} : note_target(step_ticks);
   assign phase_done   = tick && ((ticks_q + 9'd1) >= phase_target);
   assign is_last      = mem_last_q[step_idx_q] || (step_idx_q == ADDR_W'(STEPS - 1));

   // NOTE: every signal written here gets a default first so no path leaves
   // one unassigned and no latch is inferred.
   always_comb begin
      state_d    = state_q;
      step_idx_d = step_idx_q;
      freq_d     = freq_q;
      play_d     = play_q;
      done_d     = 1'b0;
      ticks_d    = ticks_q;
      clr        = 1'b0;
      load       = 1'b0;
      load_idx   = '0;

      if (tick && (state_q != ST_IDLE)) ticks_d = ticks_q + 9'd1;

      unique case (state_q)
         ST_IDLE: begin
            if (start) load = 1'b1;
         end
         ST_NOTE, ST_GAP: begin
            if (phase_done) begin
               if ((state_q == ST_NOTE) && (gap_ticks != 8'd0)) begin
                  state_d = ST_GAP;
                  play_d  = 1'b0;
                  ticks_d = '0;
                  clr     = 1'b1;
               end else if (!is_last) begin
                  load     = 1'b1;
                  load_idx = step_idx_q + 1'b1;
               end else if (loop_en) begin
                  load = 1'b1;
               end else begin
                  state_d = ST_IDLE;
                  freq_d  = '0;
                  play_d  = 1'b0;
                  done_d  = 1'b1;
                  ticks_d = '0;
                  clr     = 1'b1;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            clr     = 1'b1;
         end
      endcase

      if (load) begin
         state_d    = ST_NOTE;
         step_idx_d = load_idx;
         freq_d     = mem_freq_q[load_idx];
         play_d     = (mem_freq_q[load_idx] != FREQ_W'(REST_CODE));
         ticks_d    = '0;
         clr        = 1'b1;
      end

      // Stop overrides everything, including a simultaneous start.
      if (stop) begin
         state_d = ST_IDLE;
         freq_d  = '0;
         play_d  = 1'b0;
         done_d  = 1'b0;
         ticks_d = '0;
         clr     = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         step_idx_q <= '0;
         freq_q     <= '0;
         play_q     <= 1'b0;
         done_q     <= 1'b0;
         ticks_q    <= '0;
      end else begin
         state_q    <= state_d;
         step_idx_q <= step_idx_d;
         freq_q     <= freq_d;
         play_q     <= play_d;
         done_q     <= done_d;
         ticks_q    <= ticks_d;
      end
   end

   assign freq     = freq_q;
   assign play     = play_q;
   assign step_idx = step_idx_q;
   assign busy     = (state_q != ST_IDLE);
   assign done     = done_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer with TICK_DIV=4; cycle k is the k-th
// cycle after the edge that samples start.
module tb_note_sequencer;

   localparam int STEPS    = 16;
   localparam int ADDR_W   = 4;
   localparam int FREQ_W   = 12;
   localparam int TICK_DIV = 4;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              start = 1'b0;
   logic              stop = 1'b0;
   logic              loop_en = 1'b0;
   logic              wr_en = 1'b0;
   logic [ADDR_W-1:0] wr_addr = '0;
   logic [FREQ_W-1:0] wr_freq = '0;
   logic              wr_last = 1'b0;
   logic [7:0]        step_ticks = 8'd1;
   logic [7:0]        gap_ticks = 8'd0;
   logic [FREQ_W-1:0] freq;
   logic              play;
   logic [ADDR_W-1:0] step_idx;
   logic              busy;
   logic              done;

   int n_checks = 0;
   int n_fail   = 0;
   int pat [3] = '{262, 330, 392};

   note_sequencer #(
      .STEPS    (STEPS),
      .ADDR_W   (ADDR_W),
      .FREQ_W   (FREQ_W),
      .TICK_DIV (TICK_DIV)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .stop       (stop),
      .loop_en    (loop_en),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_freq    (wr_freq),
      .wr_last    (wr_last),
      .step_ticks (step_ticks),
      .gap_ticks  (gap_ticks),
      .freq       (freq),
      .play       (play),
      .step_idx   (step_idx),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic write_entry(input int addr, input int f, input logic last);
      wr_addr = ADDR_W'(addr);
      wr_freq = FREQ_W'(f);
      wr_last = last;
      wr_en   = 1'b1;
      step();
      wr_en   = 1'b0;
   endtask

   task automatic test_reset();
      int done_cnt;
      int done_at;
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      n_checks += 5;
      if (freq !== 12'd0)   begin n_fail++; $display("FAIL reset_freq got %0d expected 0", freq); end
      if (play !== 1'b0)    begin n_fail++; $display("FAIL reset_play got %0b expected 0", play); end
      if (busy !== 1'b0)    begin n_fail++; $display("FAIL reset_busy got %0b expected 0", busy); end
      if (step_idx !== 4'd0) begin n_fail++; $display("FAIL reset_step_idx got %0d expected 0", step_idx); end
      if (done !== 1'b0)    begin n_fail++; $display("FAIL reset_done got %0b expected 0", done); end

      // Empty pattern: 16 rest steps of 4 cycles, done at k=65.
      loop_en = 1'b0; step_ticks = 8'd1; gap_ticks = 8'd0;
      pulse_start();
      done_cnt = 0;
      done_at  = 0;
      for (int k = 1; k <= 70; k++) begin
         n_checks++;
         if (play !== 1'b0) begin n_fail++; $display("FAIL empty_play k=%0d got %0b expected 0", k, play); end
         if (k <= 64) begin
            n_checks++;
            if (step_idx !== 4'((k - 1) / 4)) begin
               n_fail++; $display("FAIL empty_step_idx k=%0d got %0d expected %0d", k, step_idx, (k - 1) / 4);
            end
         end
         if (done === 1'b1) begin done_cnt++; done_at = k; end
         step();
      end
      n_checks += 2;
      if (done_cnt != 1) begin n_fail++; $display("FAIL empty_done_count got %0d expected 1", done_cnt); end
      if (done_at != 65) begin n_fail++; $display("FAIL empty_done_cycle got %0d expected 65", done_at); end
   endtask

   task automatic test_three_note();
      int exp_f;
      write_entry(0, 262, 1'b0);
      write_entry(1, 330, 1'b0);
      write_entry(2, 392, 1'b1);
      loop_en = 1'b0; step_ticks = 8'd2; gap_ticks = 8'd0;
      pulse_start();
      for (int k = 1; k <= 28; k++) begin
         exp_f = (k <= 8) ? 262 : (k <= 16) ? 330 : (k <= 24) ? 392 : 0;
         n_checks += 3;
         if (freq !== FREQ_W'(exp_f)) begin n_fail++; $display("FAIL three_freq k=%0d got %0d expected %0d", k, freq, exp_f); end
         if (play !== (exp_f != 0))   begin n_fail++; $display("FAIL three_play k=%0d got %0b expected %0b", k, play, exp_f != 0); end
         if (done !== (k == 25))      begin n_fail++; $display("FAIL three_done k=%0d got %0b expected %0b", k, done, k == 25); end
         step();
      end
   endtask

   task automatic test_gap();
      int exp_f;
      logic exp_p;
      loop_en = 1'b0; step_ticks = 8'd3; gap_ticks = 8'd1;
      pulse_start();
      for (int k = 1; k <= 50; k++) begin
         if (k <= 48) begin
            exp_f = pat[(k - 1) / 16];
            exp_p = ((k - 1) % 16) < 12;
         end else begin
            exp_f = 0;
            exp_p = 1'b0;
         end
         n_checks += 3;
         if (freq !== FREQ_W'(exp_f)) begin n_fail++; $display("FAIL gap_freq k=%0d got %0d expected %0d", k, freq, exp_f); end
         if (play !== exp_p)          begin n_fail++; $display("FAIL gap_play k=%0d got %0b expected %0b", k, play, exp_p); end
         if (done !== (k == 49))      begin n_fail++; $display("FAIL gap_done k=%0d got %0b expected %0b", k, done, k == 49); end
         step();
      end
   endtask

   task automatic test_loop_stop();
      loop_en = 1'b1; step_ticks = 8'd1; gap_ticks = 8'd0;
      pulse_start();
      for (int k = 1; k <= 18; k++) begin
         n_checks += 3;
         if (step_idx !== 4'(((k - 1) / 4) % 3)) begin
            n_fail++; $display("FAIL loop_step_idx k=%0d got %0d expected %0d", k, step_idx, ((k - 1) / 4) % 3);
         end
         if (busy !== 1'b1) begin n_fail++; $display("FAIL loop_busy k=%0d got %0b expected 1", k, busy); end
         if (done !== 1'b0) begin n_fail++; $display("FAIL loop_done k=%0d got %0b expected 0", k, done); end
         if (k < 18) step();
      end
      stop = 1'b1;
      step();
      stop = 1'b0;
      n_checks += 4;
      if (play !== 1'b0)  begin n_fail++; $display("FAIL stop_play got %0b expected 0", play); end
      if (freq !== 12'd0) begin n_fail++; $display("FAIL stop_freq got %0d expected 0", freq); end
      if (busy !== 1'b0)  begin n_fail++; $display("FAIL stop_busy got %0b expected 0", busy); end
      if (done !== 1'b0)  begin n_fail++; $display("FAIL stop_done got %0b expected 0", done); end
      for (int k = 0; k < 10; k++) begin
         step();
         n_checks += 2;
         if (done !== 1'b0) begin n_fail++; $display("FAIL stop_after_done t=%0d got %0b expected 0", k, done); end
         if (busy !== 1'b0) begin n_fail++; $display("FAIL stop_after_busy t=%0d got %0b expected 0", k, busy); end
      end
   endtask

   task automatic test_corners();
      int exp_idx;
      start = 1'b1; stop = 1'b1;
      step();
      start = 1'b0; stop = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         n_checks += 2;
         if (busy !== 1'b0) begin n_fail++; $display("FAIL startstop_busy k=%0d got %0b expected 0", k, busy); end
         if (play !== 1'b0) begin n_fail++; $display("FAIL startstop_play k=%0d got %0b expected 0", k, play); end
         step();
      end

      // step_ticks=0 gives 4-cycle notes; a start at k=6 must not restart.
      loop_en = 1'b0; step_ticks = 8'd0; gap_ticks = 8'd0;
      pulse_start();
      for (int k = 1; k <= 14; k++) begin
         exp_idx = (k <= 12) ? (k - 1) / 4 : 2;
         n_checks += 3;
         if (step_idx !== 4'(exp_idx)) begin n_fail++; $display("FAIL corner_step_idx k=%0d got %0d expected %0d", k, step_idx, exp_idx); end
         if (busy !== (k <= 12)) begin n_fail++; $display("FAIL corner_busy k=%0d got %0b expected %0b", k, busy, k <= 12); end
         if (done !== (k == 13)) begin n_fail++; $display("FAIL corner_done k=%0d got %0b expected %0b", k, done, k == 13); end
         start = (k == 6);
         step();
      end
      start = 1'b0;
   endtask

   task automatic test_write_during_play();
      int exp_f;
      int s;
      loop_en = 1'b1; step_ticks = 8'd1; gap_ticks = 8'd0;
      wr_addr = 4'd1; wr_freq = 12'd440; wr_last = 1'b0;
      pulse_start();
      for (int k = 1; k <= 18; k++) begin
         s = ((k - 1) / 4) % 3;
         exp_f = (s == 1 && k >= 17) ? 440 : pat[s];
         n_checks++;
         if (freq !== FREQ_W'(exp_f)) begin n_fail++; $display("FAIL wrplay_freq k=%0d got %0d expected %0d", k, freq, exp_f); end
         wr_en = (k == 6);
         if (k < 18) step();
      end
      wr_en = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      n_checks += 5;
      if (freq !== 12'd0)    begin n_fail++; $display("FAIL midrst_freq got %0d expected 0", freq); end
      if (play !== 1'b0)     begin n_fail++; $display("FAIL midrst_play got %0b expected 0", play); end
      if (busy !== 1'b0)     begin n_fail++; $display("FAIL midrst_busy got %0b expected 0", busy); end
      if (step_idx !== 4'd0) begin n_fail++; $display("FAIL midrst_step_idx got %0d expected 0", step_idx); end
      if (done !== 1'b0)     begin n_fail++; $display("FAIL midrst_done got %0b expected 0", done); end

      loop_en = 1'b0;
      pulse_start();
      for (int k = 1; k <= 8; k++) begin
         n_checks += 3;
         if (freq !== 12'd0) begin n_fail++; $display("FAIL cleared_freq k=%0d got %0d expected 0", k, freq); end
         if (busy !== 1'b1)  begin n_fail++; $display("FAIL cleared_busy k=%0d got %0b expected 1", k, busy); end
         if (step_idx !== 4'((k - 1) / 4)) begin
            n_fail++; $display("FAIL cleared_step_idx k=%0d got %0d expected %0d", k, step_idx, (k - 1) / 4);
         end
         step();
      end
      stop = 1'b1;
      step();
      stop = 1'b0;
   endtask

   initial begin
      test_reset();
      test_three_note();
      test_gap();
      test_loop_stop();
      test_corners();
      test_write_during_play();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
